outpkt_src: RTL and testbench

OUTPKT_SRC -- requirements
Module: outpkt_src

---
 rtl/outpkt_src_pkg.sv | 28 ++
 rtl/outpkt_src_if.sv | 32 +++
 rtl/outpkt_src_bank.sv | 22 ++
 rtl/outpkt_src.sv | 138 +++++++++++++
 tb/tb_outpkt_src.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/outpkt_src_pkg.sv
// Shared output-packet definitions: packet type codes, default result
// length and the MSB() width helper.
package outpkt_src_pkg;

  localparam int RESULT_LEN_DEF = 64;

  localparam int OUTPKT_TYPE_MSB = 3;
  localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_RESULT      = 4'h3;
  localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_CMP_RESULT  = 4'h4;
  localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_PACKET_DONE = 4'h5;

  typedef logic [1:0] bank_st_t;

  // bit 1 set means the bank holds a complete packet
  localparam bank_st_t ST_FREE    = 2'b00;
  localparam bank_st_t ST_FILLING = 2'b01;
  localparam bank_st_t ST_READY   = 2'b10;
  localparam bank_st_t ST_READING = 2'b11;

  function automatic int MSB(input int v);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++)
      if (v >= (1 << i)) r = i;
    return r;
  endfunction

endpackage

// File: rtl/outpkt_src_if.sv
// Output side of the packet source: read port, metadata and the
// wr_en/full handshake towards the packet sender.
interface outpkt_src_if
  import outpkt_src_pkg::*;
#(
  parameter int HASH_NUM_MSB = 15,
  parameter int ADDR_W       = 6
);

  logic                     source_not_empty;
  logic [15:0]              dout;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     wr_en;
  logic                     full;
  logic [OUTPKT_TYPE_MSB:0] pkt_type;
  logic [15:0]              pkt_id;
  logic [HASH_NUM_MSB:0]    hash_num;
  logic [31:0]              num_processed;

  modport master (
    output source_not_empty, dout, wr_en,
    output pkt_type, pkt_id, hash_num, num_processed,
    input  rd_addr, full
  );

  modport slave (
    input  source_not_empty, dout, wr_en,
    input  pkt_type, pkt_id, hash_num, num_processed,
    output rd_addr, full
  );

endinterface

// File: rtl/outpkt_src_bank.sv
// One packet bank: 16-bit distributed RAM, synchronous write,
// asynchronous read.
module outpkt_src_bank #(
  parameter int DEPTH = 36,
  parameter int AW    = 6
)(
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge CLK)
    if (we) mem[waddr] <= wdata;

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/outpkt_src.sv
// Ping-pong packet source: results and packet-done records are staged
// in two banks and handed to the sender strictly in arrival order.
module outpkt_src
  import outpkt_src_pkg::*;
#(
  parameter int RESULT_LEN   = RESULT_LEN_DEF,
  parameter int HASH_NUM_MSB = 15
)(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  res_wr_en,
  input  logic [15:0]           res_din,
  input  logic                  res_last,
  input  logic                  res_cmp,
  input  logic [HASH_NUM_MSB:0] res_hash_num,
  output logic                  res_full,
  input  logic                  done_wr_en,
  input  logic [15:0]           done_pkt_id,
  input  logic [31:0]           done_num_processed,
  output logic                  done_full,
  output logic                  err_overflow,
  outpkt_src_if.master          o
);

  localparam int WORDS = 4 + RESULT_LEN / 2;
  localparam int AW    = MSB(WORDS - 1) + 1;

  bank_st_t [1:0] st, st_n;
  logic           wr_ptr, rd_ptr;
  logic           wr_ptr_n, rd_ptr_n;
  logic [AW:0]    wr_addr;
  logic           sne;

  logic [1:0][OUTPKT_TYPE_MSB:0] m_type;
  logic [1:0][15:0]              m_id;
  logic [1:0][HASH_NUM_MSB:0]    m_hash;
  logic [1:0][31:0]              m_num;

  bank_st_t    wst, rst_st;
  logic        res_acc, done_acc, ovf, ram_we, rel;
  logic [15:0] rdata0, rdata1;

  assign wst    = st[wr_ptr];
  assign rst_st = st[rd_ptr];

  assign res_full  = !(wst == ST_FREE || wst == ST_FILLING);
  assign done_full = (wst != ST_FREE) || res_wr_en;
  assign res_acc   = res_wr_en && !res_full;
  assign done_acc  = done_wr_en && !done_full;
  assign ovf       = res_acc && (wr_addr == (AW+1)'(WORDS));
  assign ram_we    = res_acc && !ovf;

  assign o.wr_en = (rst_st == ST_READING) && !o.full;
  assign rel     = o.wr_en;

  always_comb begin
    st_n     = st;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (res_acc) begin
      st_n[wr_ptr] = res_last ? ST_READY : ST_FILLING;
      if (res_last) wr_ptr_n = !wr_ptr;
    end else if (done_acc) begin
      st_n[wr_ptr] = ST_READY;
      wr_ptr_n     = !wr_ptr;
    end
    if (rel) begin
      st_n[rd_ptr] = ST_FREE;
      rd_ptr_n     = !rd_ptr;
    end else if (sne && rst_st == ST_READY) begin
      st_n[rd_ptr] = ST_READING;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st           <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_addr      <= '0;
      sne          <= 1'b0;
      err_overflow <= 1'b0;
      m_type       <= '0;
      m_id         <= '0;
      m_hash       <= '0;
      m_num        <= '0;
    end else begin
      st     <= st_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      sne    <= st_n[rd_ptr_n][1];
      if (ovf) err_overflow <= 1'b1;
      if (res_acc) begin
        if (res_last)  wr_addr <= '0;
        else if (!ovf) wr_addr <= wr_addr + 1'b1;
        if (wr_addr == (AW+1)'(1)) m_id[wr_ptr] <= res_din;
        if (res_last) begin
          m_type[wr_ptr] <= res_cmp ? OUTPKT_TYPE_CMP_RESULT
                                    : OUTPKT_TYPE_RESULT;
          m_hash[wr_ptr] <= res_cmp ? res_hash_num : '0;
          m_num[wr_ptr]  <= '0;
        end
      end else if (done_acc) begin
        m_type[wr_ptr] <= OUTPKT_TYPE_PACKET_DONE;
        m_id[wr_ptr]   <= done_pkt_id;
        m_hash[wr_ptr] <= '0;
        m_num[wr_ptr]  <= done_num_processed;
      end
    end
  end

  outpkt_src_bank #(.DEPTH(WORDS), .AW(AW)) u_bank0 (
    .CLK   (CLK),
    .we    (ram_we && !wr_ptr),
    .waddr (wr_addr[AW-1:0]),
    .wdata (res_din),
    .raddr (o.rd_addr),
    .rdata (rdata0)
  );

  outpkt_src_bank #(.DEPTH(WORDS), .AW(AW)) u_bank1 (
    .CLK   (CLK),
    .we    (ram_we && wr_ptr),
    .waddr (wr_addr[AW-1:0]),
    .wdata (res_din),
    .raddr (o.rd_addr),
    .rdata (rdata1)
  );

  assign o.dout             = rd_ptr ? rdata1 : rdata0;
  assign o.source_not_empty = sne;
  // metadata is only meaningful while a packet is on offer
  assign o.pkt_type      = sne ? m_type[rd_ptr] : '0;
  assign o.pkt_id        = sne ? m_id[rd_ptr]   : '0;
  assign o.hash_num      = sne ? m_hash[rd_ptr] : '0;
  assign o.num_processed = sne ? m_num[rd_ptr]  : '0;

endmodule

// File: tb/tb_outpkt_src.sv
// Directed bench for outpkt_src: ordering, backpressure, overflow and
// reset behaviour with hand-computed expectations.
module tb_outpkt_src;
  import outpkt_src_pkg::*;

  localparam int HMSB = 15;
  localparam int AW   = 6;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            res_wr_en = 1'b0;
  logic [15:0]     res_din = '0;
  logic            res_last = 1'b0;
  logic            res_cmp = 1'b0;
  logic [HMSB:0]   res_hash_num = '0;
  logic            res_full;
  logic            done_wr_en = 1'b0;
  logic [15:0]     done_pkt_id = '0;
  logic [31:0]     done_num_processed = '0;
  logic            done_full;
  logic            err_overflow;

  int n_vec = 0;
  int n_err = 0;
  int pulses;

  outpkt_src_if #(.HASH_NUM_MSB(HMSB), .ADDR_W(AW)) o ();

  outpkt_src #(.RESULT_LEN(64), .HASH_NUM_MSB(HMSB)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .res_wr_en          (res_wr_en),
    .res_din            (res_din),
    .res_last           (res_last),
    .res_cmp            (res_cmp),
    .res_hash_num       (res_hash_num),
    .res_full           (res_full),
    .done_wr_en         (done_wr_en),
    .done_pkt_id        (done_pkt_id),
    .done_num_processed (done_num_processed),
    .done_full          (done_full),
    .err_overflow       (err_overflow),
    .o                  (o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_res(input logic [15:0] base, input int n,
                          input bit last, input bit cmp,
                          input logic [15:0] h);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      res_wr_en    = 1'b1;
      res_din      = base + 16'(i);
      res_last     = last && (i == n - 1);
      res_cmp      = cmp;
      res_hash_num = h;
    end
    @(negedge CLK);
    res_wr_en = 1'b0;
    res_last  = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input logic [3:0] t,
                            input logic [15:0] id, input logic [15:0] h,
                            input logic [31:0] num);
    bit seen;
    seen   = 1'b0;
    o.full = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      #1;
      if (o.wr_en) begin
        seen = 1'b1;
        chk({tag, "_type"}, o.pkt_type, t);
        chk({tag, "_id"}, o.pkt_id, id);
        chk({tag, "_hash"}, o.hash_num, h);
        chk({tag, "_num"}, o.num_processed, num);
      end
      @(negedge CLK);
    end
    #1;
    chk({tag, "_pulse"}, o.wr_en, 1'b0);
    o.full = 1'b1;
    chk({tag, "_seen"}, seen, 1'b1);
  endtask

  initial begin
    o.full    = 1'b1;
    o.rd_addr = '0;
    repeat (2) @(negedge CLK);
    chk("rst_sne", o.source_not_empty, 0);
    chk("rst_wr_en", o.wr_en, 0);
    chk("rst_res_full", res_full, 0);
    chk("rst_done_full", done_full, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_type", o.pkt_type, 0);
    chk("rst_id", o.pkt_id, 0);
    chk("rst_num", o.num_processed, 0);
    RST = 1'b0;

    // full CMP_RESULT packet
    send_res(16'h1000, 36, 1'b1, 1'b1, 16'd5);
    chk("c1_sne", o.source_not_empty, 1);
    chk("c1_type", o.pkt_type, OUTPKT_TYPE_CMP_RESULT);
    chk("c1_id", o.pkt_id, 16'h1001);
    chk("c1_hash", o.hash_num, 5);
    chk("c1_num", o.num_processed, 0);
    chk("c1_res_full", res_full, 0);
    o.rd_addr = 6'd4;  #1 chk("c1_dout4", o.dout, 16'h1004);
    o.rd_addr = 6'd0;  #1 chk("c1_dout0", o.dout, 16'h1000);
    o.rd_addr = 6'd35; #1 chk("c1_dout35", o.dout, 16'h1023);

    // downstream held full for 20 cycles
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (o.wr_en) pulses++;
    end
    chk("hold_pulses", pulses, 0);
    o.full = 1'b0;
    #1 chk("hold_first", o.wr_en, 1);
    @(negedge CLK);
    #1 chk("hold_drop", o.wr_en, 0);
    chk("hold_sne", o.source_not_empty, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (o.wr_en) pulses++;
    end
    chk("hold_once", pulses, 0);
    o.full = 1'b1;

    // two back-to-back results, third refused
    send_res(16'h2000, 36, 1'b1, 1'b0, 16'd9);
    send_res(16'h3000, 36, 1'b1, 1'b0, 16'd0);
    chk("bb_res_full", res_full, 1);
    chk("bb_done_full", done_full, 1);
    chk("bb_id", o.pkt_id, 16'h2001);
    chk("bb_hash0", o.hash_num, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      res_wr_en = 1'b1;
      res_din   = 16'h4000 + 16'(i);
      #1 chk("bb_refuse", res_full, 1);
    end
    @(negedge CLK);
    res_wr_en = 1'b0;
    expect_pkt("p2", OUTPKT_TYPE_RESULT, 16'h2001, 16'h0, 32'h0);
    chk("bb_free", res_full, 0);
    chk("bb_sne", o.source_not_empty, 1);
    chk("bb_next_id", o.pkt_id, 16'h3001);
    send_res(16'h4000, 4, 1'b1, 1'b1, 16'd7);
    expect_pkt("p3", OUTPKT_TYPE_RESULT, 16'h3001, 16'h0, 32'h0);
    expect_pkt("p4", OUTPKT_TYPE_CMP_RESULT, 16'h4001, 16'h7, 32'h0);

    // result then packet-done keeps order
    send_res(16'h5000, 36, 1'b1, 1'b0, 16'd0);
    @(negedge CLK);
    done_wr_en         = 1'b1;
    done_pkt_id        = 16'h0007;
    done_num_processed = 32'h0001_0000;
    #1 chk("d_accept", done_full, 0);
    @(negedge CLK);
    done_wr_en = 1'b0;
    expect_pkt("p5", OUTPKT_TYPE_RESULT, 16'h5001, 16'h0, 32'h0);
    expect_pkt("p6", OUTPKT_TYPE_PACKET_DONE, 16'h0007, 16'h0,
               32'h0001_0000);

    // same-cycle result and done: result wins
    @(negedge CLK);
    res_wr_en   = 1'b1;
    res_din     = 16'h6000;
    res_cmp     = 1'b0;
    res_last    = 1'b0;
    done_wr_en  = 1'b1;
    done_pkt_id = 16'h0099;
    #1 chk("cf_done_full", done_full, 1);
    @(negedge CLK);
    done_wr_en = 1'b0;
    res_din    = 16'h6001;
    res_last   = 1'b1;
    @(negedge CLK);
    res_wr_en = 1'b0;
    res_last  = 1'b0;
    expect_pkt("p7", OUTPKT_TYPE_RESULT, 16'h6001, 16'h0, 32'h0);
    repeat (3) @(negedge CLK);
    chk("cf_no_done", o.source_not_empty, 0);

    // overflow: 37 words without res_last
    send_res(16'h7000, 37, 1'b0, 1'b0, 16'd0);
    chk("ov_err", err_overflow, 1);
    chk("ov_sne", o.source_not_empty, 0);
    @(negedge CLK);
    res_wr_en = 1'b1;
    res_din   = 16'h7FFF;
    res_last  = 1'b1;
    @(negedge CLK);
    res_wr_en = 1'b0;
    res_last  = 1'b0;
    chk("ov_sne_done", o.source_not_empty, 1);
    o.rd_addr = 6'd35; #1 chk("ov_dout35", o.dout, 16'h7023);
    o.rd_addr = 6'd1;  #1 chk("ov_dout1", o.dout, 16'h7001);
    chk("ov_err_hold", err_overflow, 1);
    RST = 1'b1;
    #1 chk("ov_rst_err", err_overflow, 0);
    chk("ov_rst_sne", o.source_not_empty, 0);
    chk("ov_rst_type", o.pkt_type, 0);
    chk("ov_rst_id", o.pkt_id, 0);
    @(negedge CLK);
    RST = 1'b0;

    // reset during READING
    send_res(16'h8000, 4, 1'b1, 1'b0, 16'd0);
    @(negedge CLK);
    o.full = 1'b0;
    #1 chk("rr_pre", o.wr_en, 1);
    RST = 1'b1;
    #1 chk("rr_wr_en", o.wr_en, 0);
    chk("rr_sne", o.source_not_empty, 0);
    chk("rr_res_full", res_full, 0);
    @(negedge CLK);
    RST = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (o.wr_en || o.source_not_empty) pulses++;
    end
    chk("rr_quiet", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
